// File: rtl/inventory_tracker.sv
// Per-stock position tracker: accepts buy/sell fills, clamps positions to a shared
// absolute limit and keeps a saturated Q.32 normalised inventory per stock.
module inventory_tracker #(
    parameter int NUM_STOCKS   = 4,
    parameter int QTY_WIDTH    = 16,
    parameter int POS_WIDTH    = 24,
    parameter int FP_WORD_SIZE = 64
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_fill_valid,
    output logic                          o_fill_ready,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_fill_stock_id,
    input  logic [QTY_WIDTH-1:0]          i_fill_qty,
    input  logic                          i_fill_side,
    input  logic [FP_WORD_SIZE-1:0]       i_max_inventory_reciprocal,
    input  logic [POS_WIDTH-2:0]          i_pos_limit,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_rd_stock_id,
    output logic [FP_WORD_SIZE-1:0]       o_norm_inventory,
    output logic [POS_WIDTH-1:0]          o_position,
    output logic [NUM_STOCKS-1:0]         o_limit_hit,
    output logic                          o_clamped
);

    localparam int IDW = $clog2(NUM_STOCKS);
    localparam int PW  = POS_WIDTH;
    localparam int FW  = FP_WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        NORM
    } state_e;

    state_e state_q, state_d;
    logic   init_q;
    logic   accept;
    logic   pos_we;
    logic   norm_we;

    logic [IDW-1:0]       id_q;
    logic [QTY_WIDTH-1:0] qty_q;
    logic                 side_q;

    logic signed [PW-1:0] pos_q  [NUM_STOCKS];
    logic signed [FW-1:0] norm_q [NUM_STOCKS];

    logic [FW-1:0]         rd_norm_q;
    logic [PW-1:0]         rd_pos_q;
    logic [NUM_STOCKS-1:0] hit_q, hit_d;
    logic                  clamped_q;

    logic signed [PW-1:0]    cur_pos;
    logic signed [PW:0]      cur_ext, qty_ext, lim_ext, sum, clip;
    logic signed [PW-1:0]    new_pos;
    logic                    clamp_hit;
    logic signed [PW+FW:0]   pos_wide, recip_wide, prod, fp_max_ext, fp_min_ext;
    logic signed [FW-1:0]    norm_val;
    logic [PW-1:0]           mag;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = UPDATE;
            UPDATE:  state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready stays low while in reset and rises on the first edge after release.
    always_comb begin
        o_fill_ready = init_q && (state_q == IDLE);
        accept       = i_fill_valid && o_fill_ready;
        pos_we       = (state_q == UPDATE);
        norm_we      = (state_q == NORM);
    end

    // ------------------------------------------------------------ fill latch
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            id_q   <= '0;
            qty_q  <= '0;
            side_q <= 1'b0;
        end else if (accept) begin
            id_q   <= i_fill_stock_id;
            qty_q  <= i_fill_qty;
            side_q <= i_fill_side;
        end
    end

    // ------------------------------------------------------ update datapath
    always_comb begin
        cur_pos = pos_q[id_q];
        cur_ext = {cur_pos[PW-1], cur_pos};
        qty_ext = {{(PW + 1 - QTY_WIDTH){1'b0}}, qty_q};
        lim_ext = {2'b00, i_pos_limit};
        sum     = side_q ? (cur_ext - qty_ext) : (cur_ext + qty_ext);
        if (sum > lim_ext) begin
            clip = lim_ext;
        end else if (sum < -lim_ext) begin
            clip = -lim_ext;
        end else begin
            clip = sum;
        end
        new_pos   = clip[PW-1:0];
        clamp_hit = (sum != clip) || ((i_pos_limit == '0) && (qty_q != '0));
    end

    // NORM reads the position written during UPDATE; integer * Q.32 is already Q.32.
    always_comb begin
        pos_wide   = {{(FW + 1){cur_pos[PW-1]}}, cur_pos};
        recip_wide = {{(PW + 1){1'b0}}, i_max_inventory_reciprocal};
        prod       = pos_wide * recip_wide;
        fp_max_ext = {{(PW + 2){1'b0}}, {(FW - 1){1'b1}}};
        fp_min_ext = {{(PW + 2){1'b1}}, {(FW - 1){1'b0}}};
        if (prod > fp_max_ext) begin
            norm_val = {1'b0, {(FW - 1){1'b1}}};
        end else if (prod < fp_min_ext) begin
            norm_val = {1'b1, {(FW - 1){1'b0}}};
        end else begin
            norm_val = prod[FW-1:0];
        end
    end

    // --------------------------------------------------------------- storage
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
                pos_q[i]  <= '0;
                norm_q[i] <= '0;
            end
        end else begin
            if (pos_we)  pos_q[id_q]  <= new_pos;
            if (norm_we) norm_q[id_q] <= norm_val;
        end
    end

    // Limit flags follow the stored positions and the live limit every cycle.
    always_comb begin
        hit_d = '0;
        mag   = '0;
        for (int unsigned i = 0; i < NUM_STOCKS; i++) begin
            mag      = pos_q[i][PW-1] ? -pos_q[i] : pos_q[i];
            hit_d[i] = (mag >= {1'b0, i_pos_limit});
        end
    end

    // ---------------------------------------------------------------- outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_norm_q <= '0;
            rd_pos_q  <= '0;
            hit_q     <= '0;
            clamped_q <= 1'b0;
        end else begin
            rd_norm_q <= norm_q[i_rd_stock_id];
            rd_pos_q  <= pos_q[i_rd_stock_id];
            hit_q     <= hit_d;
            clamped_q <= pos_we && clamp_hit;
        end
    end

    assign o_norm_inventory = rd_norm_q;
    assign o_position       = rd_pos_q;
    assign o_limit_hit      = hit_q;
    assign o_clamped        = clamped_q;

endmodule

// File: tb/tb_inventory_tracker.sv
// Self-checking bench for inventory_tracker: directed scenarios plus randomized
// fills compared against an arithmetic reference model of positions and norms.
module tb_inventory_tracker;

    localparam int NS  = 4;
    localparam int QW  = 16;
    localparam int PW  = 24;
    localparam int FW  = 64;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            fill_valid = 1'b0;
    logic            fill_ready;
    logic [IDW-1:0]  fill_id = '0;
    logic [QW-1:0]   fill_qty = '0;
    logic            fill_side = 1'b0;
    logic [FW-1:0]   recip = '0;
    logic [PW-2:0]   lim = '0;
    logic [IDW-1:0]  rd_id = '0;
    logic [FW-1:0]   norm;
    logic [PW-1:0]   pos;
    logic [NS-1:0]   hit;
    logic            clamped;

    int              n_checks = 0;
    int              n_fail = 0;

    int              m_pos  [NS];
    logic [FW-1:0]   m_norm [NS];

    inventory_tracker #(
        .NUM_STOCKS  (NS),
        .QTY_WIDTH   (QW),
        .POS_WIDTH   (PW),
        .FP_WORD_SIZE(FW)
    ) dut (
        .i_clk                     (clk),
        .i_reset_n                 (rst_n),
        .i_fill_valid              (fill_valid),
        .o_fill_ready              (fill_ready),
        .i_fill_stock_id           (fill_id),
        .i_fill_qty                (fill_qty),
        .i_fill_side               (fill_side),
        .i_max_inventory_reciprocal(recip),
        .i_pos_limit               (lim),
        .i_rd_stock_id             (rd_id),
        .o_norm_inventory          (norm),
        .o_position                (pos),
        .o_limit_hit               (hit),
        .o_clamped                 (clamped)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------- reference model
    function automatic logic [FW-1:0] model_norm(input int p, input logic [FW-1:0] r);
        logic signed [127:0] a, b, prod, mx, mn;
        a    = 128'(p);
        b    = {64'd0, r};
        prod = a * b;
        mx   = 128'sh7FFF_FFFF_FFFF_FFFF;
        mn   = -mx - 128'sd1;
        if (prod > mx) return 64'h7FFF_FFFF_FFFF_FFFF;
        if (prod < mn) return 64'h8000_0000_0000_0000;
        return prod[63:0];
    endfunction

    function automatic logic [NS-1:0] model_hit();
        logic [NS-1:0] h;
        int mag;
        h = '0;
        for (int i = 0; i < NS; i++) begin
            mag  = (m_pos[i] < 0) ? -m_pos[i] : m_pos[i];
            h[i] = (mag >= int'(lim));
        end
        return h;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pos[i]  = 0;
            m_norm[i] = '0;
        end
    endtask

    task automatic model_apply(input int id, input int qty, input bit side, output int exp_pulses);
        int raw, l, c;
        l   = int'(lim);
        raw = m_pos[id] + (side ? -qty : qty);
        c   = (raw > l) ? l : ((raw < -l) ? -l : raw);
        exp_pulses = ((c != raw) || (l == 0 && qty != 0)) ? 1 : 0;
        m_pos[id]  = c;
        m_norm[id] = model_norm(c, recip);
    endtask

    // ------------------------------------------------------- stimulus helpers
    task automatic do_fill(input int id, input int qty, input bit side,
                           output int pulses, output int exp_pulses);
        int wait_cnt;
        wait_cnt   = 0;
        pulses     = 0;
        exp_pulses = 0;
        fill_id    = id[IDW-1:0];
        fill_qty   = qty[QW-1:0];
        fill_side  = side;
        fill_valid = 1'b1;
        while (!fill_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!fill_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL fill_ready_timeout: ready=%0b required=1", fill_ready);
            fill_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        fill_valid = 1'b0;
        model_apply(id, qty, side, exp_pulses);
        repeat (3) begin
            if (clamped) pulses++;
            @(posedge clk); #1;
        end
    endtask

    task automatic read_stock(input int id);
        rd_id = id[IDW-1:0];
        @(posedge clk); #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (fill_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got=%0b exp=0", fill_ready); end
        n_checks++; if (pos !== '0) begin n_fail++; $display("FAIL reset_pos: got=%0h exp=0", pos); end
        n_checks++; if (norm !== '0) begin n_fail++; $display("FAIL reset_norm: got=%0h exp=0", norm); end
        n_checks++; if (hit !== '0) begin n_fail++; $display("FAIL reset_hit: got=%b exp=0", hit); end
        n_checks++; if (clamped !== 1'b0) begin n_fail++; $display("FAIL reset_clamped: got=%0b exp=0", clamped); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        n_checks++; if (fill_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got=%0b exp=0", fill_ready); end
        @(posedge clk); #1;
        n_checks++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got=%0b exp=1", fill_ready); end
        model_reset();
    endtask

    task automatic test_directed();
        int pl, ep;
        logic [FW-1:0] exp_norm;
        recip = 64'h0000_0000_0041_8937;
        lim   = 23'd1000;
        do_fill(0, 500, 1'b0, pl, ep);
        read_stock(0);
        n_checks++; if (pos !== 24'd500) begin n_fail++; $display("FAIL buy500_pos: got=%0d exp=500", $signed(pos)); end
        n_checks++; if (norm !== 64'h0000_0000_7FFF_FF6C) begin n_fail++; $display("FAIL buy500_norm: got=%0h exp=7fffff6c", norm); end
        n_checks++; if (hit !== 4'b0000) begin n_fail++; $display("FAIL buy500_hit: got=%b exp=0000", hit); end
        n_checks++; if (pl !== 0) begin n_fail++; $display("FAIL buy500_clamp: got=%0d exp=0", pl); end

        do_fill(0, 800, 1'b0, pl, ep);
        read_stock(0);
        n_checks++; if (pos !== 24'd1000) begin n_fail++; $display("FAIL buy800_pos: got=%0d exp=1000", $signed(pos)); end
        n_checks++; if (pl !== 1) begin n_fail++; $display("FAIL buy800_clamp_pulses: got=%0d exp=1", pl); end
        n_checks++; if (hit !== 4'b0001) begin n_fail++; $display("FAIL buy800_hit: got=%b exp=0001", hit); end

        do_fill(2, 300, 1'b1, pl, ep);
        read_stock(2);
        exp_norm = -64'sd1288490100;
        n_checks++; if (int'($signed(pos)) !== -300) begin n_fail++; $display("FAIL sell300_pos: got=%0d exp=-300", $signed(pos)); end
        n_checks++; if (norm !== exp_norm) begin n_fail++; $display("FAIL sell300_norm: got=%0h exp=%0h", norm, exp_norm); end
        read_stock(0);
        n_checks++; if (pos !== 24'd1000) begin n_fail++; $display("FAIL sell300_other_pos: got=%0d exp=1000", $signed(pos)); end
    endtask

    task automatic test_mid_update_read();
        int pl, ep;
        logic [FW-1:0] old_norm;
        int old_pos;
        do_fill(3, 200, 1'b0, pl, ep);
        read_stock(3);
        old_norm = m_norm[3];
        old_pos  = m_pos[3];
        fill_id = 2'd3; fill_qty = 16'd100; fill_side = 1'b0; fill_valid = 1'b1;
        n_checks++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL midread_ready: got=%0b exp=1", fill_ready); end
        @(posedge clk); #1;
        fill_valid = 1'b0;
        model_apply(3, 100, 1'b0, ep);
        n_checks++; if (norm !== old_norm) begin n_fail++; $display("FAIL midread_c0_norm: got=%0h exp=%0h", norm, old_norm); end
        @(posedge clk); #1;
        n_checks++; if (int'($signed(pos)) !== old_pos) begin n_fail++; $display("FAIL midread_c1_pos: got=%0d exp=%0d", $signed(pos), old_pos); end
        n_checks++; if (norm !== old_norm) begin n_fail++; $display("FAIL midread_c1_norm: got=%0h exp=%0h", norm, old_norm); end
        @(posedge clk); #1;
        n_checks++; if (int'($signed(pos)) !== m_pos[3]) begin n_fail++; $display("FAIL midread_c2_pos: got=%0d exp=%0d", $signed(pos), m_pos[3]); end
        n_checks++; if (norm !== old_norm) begin n_fail++; $display("FAIL midread_c2_norm: got=%0h exp=%0h", norm, old_norm); end
        @(posedge clk); #1;
        n_checks++; if (norm !== m_norm[3]) begin n_fail++; $display("FAIL midread_c3_norm: got=%0h exp=%0h", norm, m_norm[3]); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        int acc, ep;
        acc = 0;
        seen = '0;
        fill_id = 2'd1; fill_qty = 16'd10; fill_side = 1'b0; fill_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            seen[5-k] = fill_ready;
            if (fill_ready && fill_valid) acc++;
            @(posedge clk); #1;
        end
        fill_valid = 1'b0;
        model_apply(1, 10, 1'b0, ep);
        model_apply(1, 10, 1'b0, ep);
        n_checks++; if (seen !== 6'b100100) begin n_fail++; $display("FAIL b2b_ready_pattern: got=%b exp=100100", seen); end
        n_checks++; if (acc !== 2) begin n_fail++; $display("FAIL b2b_accepts: got=%0d exp=2", acc); end
        read_stock(1);
        n_checks++; if (int'($signed(pos)) !== m_pos[1]) begin n_fail++; $display("FAIL b2b_pos: got=%0d exp=%0d", $signed(pos), m_pos[1]); end
        n_checks++; if (norm !== m_norm[1]) begin n_fail++; $display("FAIL b2b_norm: got=%0h exp=%0h", norm, m_norm[1]); end
    endtask

    task automatic test_reset_mid();
        rd_id = 2'd1;
        fill_id = 2'd1; fill_qty = 16'd100; fill_side = 1'b0; fill_valid = 1'b1;
        n_checks++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got=%0b exp=1", fill_ready); end
        @(posedge clk); #1;
        fill_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pos !== '0) begin n_fail++; $display("FAIL rstmid_pos: got=%0h exp=0", pos); end
        n_checks++; if (norm !== '0) begin n_fail++; $display("FAIL rstmid_norm: got=%0h exp=0", norm); end
        n_checks++; if (hit !== '0) begin n_fail++; $display("FAIL rstmid_hit: got=%b exp=0", hit); end
        n_checks++; if (clamped !== 1'b0) begin n_fail++; $display("FAIL rstmid_clamped: got=%0b exp=0", clamped); end
        n_checks++; if (fill_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_low: got=%0b exp=0", fill_ready); end
        #10 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (fill_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_release: got=%0b exp=1", fill_ready); end
        read_stock(1);
        n_checks++; if (pos !== '0) begin n_fail++; $display("FAIL rstmid_stock1_pos: got=%0d exp=0", $signed(pos)); end
        n_checks++; if (norm !== '0) begin n_fail++; $display("FAIL rstmid_stock1_norm: got=%0h exp=0", norm); end
    endtask

    task automatic test_limits();
        int pl, ep;
        lim = '0;
        @(posedge clk); #1;
        n_checks++; if (hit !== model_hit()) begin n_fail++; $display("FAIL zero_limit_hit: got=%b exp=%b", hit, model_hit()); end
        do_fill(2, 50, 1'b0, pl, ep);
        read_stock(2);
        n_checks++; if (pos !== '0) begin n_fail++; $display("FAIL zero_limit_pos: got=%0d exp=0", $signed(pos)); end
        n_checks++; if (pl !== 1) begin n_fail++; $display("FAIL zero_limit_clamp: got=%0d exp=1", pl); end
        do_fill(2, 0, 1'b1, pl, ep);
        n_checks++; if (pl !== 0) begin n_fail++; $display("FAIL zero_limit_qty0_clamp: got=%0d exp=0", pl); end
        lim = 23'd1000;
        @(posedge clk); #1;
        n_checks++; if (hit !== model_hit()) begin n_fail++; $display("FAIL limit_change_hit: got=%b exp=%b", hit, model_hit()); end
        do_fill(0, 700, 1'b0, pl, ep);
        do_fill(0, 0, 1'b1, pl, ep);
        read_stock(0);
        n_checks++; if (pos !== 24'd700) begin n_fail++; $display("FAIL qty0_pos: got=%0d exp=700", $signed(pos)); end
        n_checks++; if (pl !== 0) begin n_fail++; $display("FAIL qty0_clamp: got=%0d exp=0", pl); end
        lim = 23'd700;
        @(posedge clk); #1;
        n_checks++; if (hit !== model_hit()) begin n_fail++; $display("FAIL limit_equal_hit: got=%b exp=%b", hit, model_hit()); end
    endtask

    task automatic test_random();
        int id, qty, other, pl, ep;
        bit side;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) lim = 23'($urandom_range(0, 3000));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: recip = {32'd0, 32'($urandom)};
                    1: recip = 64'h0000_0001_0000_0000;
                    2: recip = {32'($urandom), 32'($urandom)};
                    default: recip = 64'h0000_0000_0041_8937;
                endcase
            end
            id   = $urandom_range(0, NS - 1);
            qty  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2500);
            side = 1'($urandom_range(0, 1));
            do_fill(id, qty, side, pl, ep);
            read_stock(id);
            n_checks++; if (int'($signed(pos)) !== m_pos[id]) begin n_fail++; $display("FAIL rand_pos[%0d]: got=%0d exp=%0d", it, $signed(pos), m_pos[id]); end
            n_checks++; if (norm !== m_norm[id]) begin n_fail++; $display("FAIL rand_norm[%0d]: got=%0h exp=%0h", it, norm, m_norm[id]); end
            n_checks++; if (hit !== model_hit()) begin n_fail++; $display("FAIL rand_hit[%0d]: got=%b exp=%b", it, hit, model_hit()); end
            n_checks++; if (pl !== ep) begin n_fail++; $display("FAIL rand_clamp[%0d]: got=%0d exp=%0d", it, pl, ep); end
            other = $urandom_range(0, NS - 1);
            read_stock(other);
            n_checks++; if (int'($signed(pos)) !== m_pos[other]) begin n_fail++; $display("FAIL rand_other_pos[%0d]: got=%0d exp=%0d", it, $signed(pos), m_pos[other]); end
            n_checks++; if (norm !== m_norm[other]) begin n_fail++; $display("FAIL rand_other_norm[%0d]: got=%0h exp=%0h", it, norm, m_norm[other]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_mid_update_read();
        test_back_to_back();
        test_reset_mid();
        test_limits();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
